sd_sector_arbiter: RTL and testbench
====================================

SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 10000000, meaning clk_sys cycles allowed in WAIT_ACK before abort (1..2^24-1).
REQ-002 SHALL have ports (clock and reset first):
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_rd  in  2  per-requester sector read request, level, bit n = requester n.
- req_wr  in  2  per-requester sector write request, level.
- req_lba_0  in  32  requester 0 sector address.
- req_lba_1  in  32  requester 1 sector address.
- req_ack  out  2  per-requester transfer-active flag.
- req_err  out  2  per-requester one-cycle timeout pulse.
- req_buff_wr  out  2  per-requester gated buffer write strobe.
- req_buff_din_0  in  8  requester 0 buffer read data.
- req_buff_din_1  in  8  requester 1 buffer read data.
- sd_lba  out  32  latched LBA to the io controller.
- sd_rd  out  1  read request to the io controller.
- sd_wr  out  1  write request to the io controller.
- sd_ack  in  1  transfer active from the io controller (SPI domain, asynchronous).
- sd_buff_wr  in  1  buffer write strobe from the io controller.
- sd_buff_din  out  8  muxed buffer data to the io controller.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the current or last owner.

Function
REQ-003 SHALL synchronise sd_ack through two clk_sys flops (ack_s); all FSM decisions SHALL use ack_s.
REQ-004 SHALL implement states IDLE, WAIT_ACK, XFER and RELEASE.
REQ-005 In IDLE, a requester is pending when its req_rd or req_wr is high.
REQ-006 If only one requester is pending, it SHALL be granted.
REQ-007 If both are pending, the requester other than the last granted one SHALL be granted (round-robin); after reset, requester 0 wins the first tie.
REQ-008 On grant, the block SHALL:
- latch the owner's LBA into sd_lba;
- set grant to the owner index;
- assert sd_rd if the owner's req_rd is high, otherwise sd_wr (read wins when both are high);
- enter WAIT_ACK on the next cycle.
The latency from request to sd_rd/sd_wr is 1 cycle.
REQ-009 In WAIT_ACK, sd_rd/sd_wr and sd_lba SHALL hold even if the owner drops its request.
REQ-010 In WAIT_ACK, a rising ack_s SHALL clear sd_rd/sd_wr, set req_ack[owner], and enter XFER.
REQ-011 In WAIT_ACK, a 24-bit counter SHALL count cycles; when it reaches TIMEOUT, the block SHALL:
- clear sd_rd/sd_wr;
- pulse req_err[owner] for one cycle;
- enter RELEASE.
REQ-012 In XFER, req_buff_wr[owner] SHALL equal sd_buff_wr combinationally; the non-owner bit SHALL be 0.
REQ-013 sd_buff_din SHALL equal req_buff_din_<grant> combinationally in all states.
REQ-014 In XFER, a falling ack_s SHALL clear req_ack[owner] and enter RELEASE; there is no timeout in XFER.
REQ-015 RELEASE SHALL last exactly one cycle and then return to IDLE, so an owner that still holds its request is not regranted before it can drop it.
REQ-016 Requests arriving outside IDLE SHALL stay pending and not be lost; changes to req_lba_n while the grant is held SHALL not affect sd_lba.
REQ-017 At most one of sd_rd/sd_wr SHALL be high at any time, and at most one req_ack bit SHALL be high.

Reset
REQ-018 Reset SHALL force, asynchronously, including mid-transfer:
- state = IDLE;
- sd_rd = sd_wr = 0, sd_lba = 0;
- req_ack = req_err = 0;
- busy = 0, grant = 0;
- ack synchronisers and timeout counter cleared;
- round-robin pointer set so requester 0 wins the first tie.

Verification
REQ-019 Req_rd=01, lba_0=0x00000123 -> next cycle sd_rd=1, sd_lba=0x123, grant=0; drive sd_ack high -> 2-3 cycles later sd_rd=0, req_ack=01.
REQ-020 During XFER of requester 1, pulse sd_buff_wr 512 times -> req_buff_wr=10 on each pulse; sd_buff_din tracks req_buff_din_1.
REQ-021 Req_rd=11 held from reset -> grants alternate 0,1,0,1 across four transfers, with a RELEASE cycle between each.
REQ-022 TIMEOUT=16, req_wr=01, sd_ack never asserted -> sd_wr falls and req_err=01 for one cycle exactly 16 cycles after WAIT_ACK entry, then IDLE.
REQ-023 Reset asserted in XFER -> sd_rd=sd_wr=0, req_ack=00, busy=0 immediately; requester 0 regranted after reset release.

Source files
------------

// File: rtl/sd_sector_arbiter.sv
// Two-requester round-robin arbiter in front of a single SD sector io controller.
// Owns the sd_rd/sd_wr handshake, ack synchronisation and the WAIT_ACK timeout.
module sd_sector_arbiter #(
   parameter int unsigned TIMEOUT = 10000000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [1:0]  req_rd,
   input  logic [1:0]  req_wr,
   input  logic [31:0] req_lba_0,
   input  logic [31:0] req_lba_1,
   output logic [1:0]  req_ack,
   output logic [1:0]  req_err,
   output logic [1:0]  req_buff_wr,
   input  logic [7:0]  req_buff_din_0,
   input  logic [7:0]  req_buff_din_1,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic        sd_buff_wr,
   output logic [7:0]  sd_buff_din,
   output logic        busy,
   output logic        grant
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      XFER     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        ack_meta_q, ack_s_q, ack_prev_q;
   logic [23:0] cnt_q, cnt_d;
   logic        sd_rd_q, sd_rd_d;
   logic        sd_wr_q, sd_wr_d;
   logic [31:0] sd_lba_q, sd_lba_d;
   logic        grant_q, grant_d;
   logic        prio_q, prio_d;
   logic [1:0]  req_ack_q, req_ack_d;
   logic [1:0]  req_err_q, req_err_d;
   logic [1:0]  pend;
   logic        sel;
   logic        ack_rise, ack_fall;

   assign pend     = req_rd | req_wr;
   assign ack_rise = ack_s_q & ~ack_prev_q;
   assign ack_fall = ~ack_s_q & ack_prev_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
         ack_prev_q <= 1'b0;
         cnt_q      <= '0;
         sd_rd_q    <= 1'b0;
         sd_wr_q    <= 1'b0;
         sd_lba_q   <= '0;
         grant_q    <= 1'b0;
         prio_q     <= 1'b0;
         req_ack_q  <= '0;
         req_err_q  <= '0;
      end else begin
         state_q    <= state_d;
         ack_meta_q <= sd_ack;
         ack_s_q    <= ack_meta_q;
         ack_prev_q <= ack_s_q;
         cnt_q      <= cnt_d;
         sd_rd_q    <= sd_rd_d;
         sd_wr_q    <= sd_wr_d;
         sd_lba_q   <= sd_lba_d;
         grant_q    <= grant_d;
         prio_q     <= prio_d;
         req_ack_q  <= req_ack_d;
         req_err_q  <= req_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      sd_rd_d   = sd_rd_q;
      sd_wr_d   = sd_wr_q;
      sd_lba_d  = sd_lba_q;
      grant_d   = grant_q;
      prio_d    = prio_q;
      req_ack_d = req_ack_q;
      req_err_d = '0;
      // prio_q names the requester that wins a tie: the one not granted last
      sel       = (pend == 2'b11) ? prio_q : pend[1];

      case (state_q)
         IDLE: begin
            if (|pend) begin
               grant_d  = sel;
               prio_d   = ~sel;
               sd_lba_d = sel ? req_lba_1 : req_lba_0;
               if (req_rd[sel]) sd_rd_d = 1'b1;
               else             sd_wr_d = 1'b1;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            cnt_d = cnt_q + 24'd1;
            if (ack_rise) begin
               sd_rd_d            = 1'b0;
               sd_wr_d            = 1'b0;
               req_ack_d[grant_q] = 1'b1;
               state_d            = XFER;
            end else if (cnt_q == TIMEOUT_LAST) begin
               sd_rd_d            = 1'b0;
               sd_wr_d            = 1'b0;
               req_err_d[grant_q] = 1'b1;
               state_d            = RELEASE;
            end
         end
         XFER: begin
            if (ack_fall) begin
               req_ack_d = '0;
               state_d   = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_buff_wr = '0;
      if (state_q == XFER) req_buff_wr[grant_q] = sd_buff_wr;
   end

   assign sd_buff_din = grant_q ? req_buff_din_1 : req_buff_din_0;
   assign busy        = (state_q != IDLE);
   assign grant       = grant_q;
   assign sd_rd       = sd_rd_q;
   assign sd_wr       = sd_wr_q;
   assign sd_lba      = sd_lba_q;
   assign req_ack     = req_ack_q;
   assign req_err     = req_err_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: grant/handshake, buffer muxing,
// round-robin, timeout and asynchronous reset during a transfer.
module tb_sd_sector_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_rd = '0, req_wr = '0;
   logic [31:0] req_lba_0 = '0, req_lba_1 = '0;
   logic [1:0]  req_ack, req_err, req_buff_wr;
   logic [7:0]  req_buff_din_0 = '0, req_buff_din_1 = '0;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr;
   logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
   logic [7:0]  sd_buff_din;
   logic        busy, grant;

   int errors = 0;
   int checks = 0;

   always #5 clk_sys = ~clk_sys;

   sd_sector_arbiter #(.TIMEOUT(16)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .req_rd(req_rd), .req_wr(req_wr),
      .req_lba_0(req_lba_0), .req_lba_1(req_lba_1),
      .req_ack(req_ack), .req_err(req_err), .req_buff_wr(req_buff_wr),
      .req_buff_din_0(req_buff_din_0), .req_buff_din_1(req_buff_din_1),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
      .busy(busy), .grant(grant)
   );

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic raise_ack();
      sd_ack = 1'b1;
      tick(3);
   endtask

   task automatic drop_ack();
      sd_ack = 1'b0;
      tick(3);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      checks++;
      if ({sd_rd, sd_wr, req_ack, req_err, busy, grant} !== 8'b0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%b wr=%b ack=%b err=%b busy=%b grant=%b expected all 0",
                  sd_rd, sd_wr, req_ack, req_err, busy, grant);
      end
      checks++;
      if (sd_lba !== 32'h0) begin
         errors++; $display("FAIL reset_lba: got %h expected 00000000", sd_lba);
      end
      reset = 1'b0;
   endtask

   task automatic test_read_grant();
      req_rd = 2'b01; req_lba_0 = 32'h0000_0123;
      tick(1);
      checks++;
      if ({sd_rd, sd_wr, grant, busy} !== 4'b1001 || sd_lba !== 32'h123) begin
         errors++;
         $display("FAIL read_grant: got rd=%b wr=%b grant=%b busy=%b lba=%h expected 1 0 0 1 00000123",
                  sd_rd, sd_wr, grant, busy, sd_lba);
      end
      req_rd = 2'b00; req_lba_0 = 32'hDEAD_BEEF;
      tick(1);
      checks++;
      if (sd_rd !== 1'b1 || sd_lba !== 32'h123) begin
         errors++; $display("FAIL wait_hold: got rd=%b lba=%h expected 1 00000123", sd_rd, sd_lba);
      end
      sd_ack = 1'b1;
      tick(2);
      checks++;
      if (sd_rd !== 1'b1 || req_ack !== 2'b00) begin
         errors++; $display("FAIL ack_sync_delay: got rd=%b ack=%b expected 1 00", sd_rd, req_ack);
      end
      tick(1);
      checks++;
      if (sd_rd !== 1'b0 || req_ack !== 2'b01) begin
         errors++; $display("FAIL ack_rise: got rd=%b ack=%b expected 0 01", sd_rd, req_ack);
      end
      sd_ack = 1'b0;
      tick(2);
      checks++;
      if (req_ack !== 2'b01) begin
         errors++; $display("FAIL ack_hold: got ack=%b expected 01", req_ack);
      end
      tick(1);
      checks++;
      if (req_ack !== 2'b00 || busy !== 1'b1) begin
         errors++; $display("FAIL release: got ack=%b busy=%b expected 00 1", req_ack, busy);
      end
      tick(1);
      checks++;
      if (busy !== 1'b0 || grant !== 1'b0) begin
         errors++; $display("FAIL back_idle: got busy=%b grant=%b expected 0 0", busy, grant);
      end
   endtask

   task automatic test_xfer_buff();
      logic [7:0] v;
      req_rd = 2'b10; req_lba_1 = 32'hABCD_0001;
      tick(1);
      checks++;
      if (grant !== 1'b1 || sd_rd !== 1'b1 || sd_lba !== 32'hABCD_0001) begin
         errors++; $display("FAIL grant1: got grant=%b rd=%b lba=%h expected 1 1 abcd0001", grant, sd_rd, sd_lba);
      end
      req_rd = 2'b00;
      raise_ack();
      checks++;
      if (req_ack !== 2'b10) begin
         errors++; $display("FAIL xfer1_ack: got %b expected 10", req_ack);
      end
      for (int i = 0; i < 512; i++) begin
         v = 8'(i);
         req_buff_din_1 = v; req_buff_din_0 = ~v;
         sd_buff_wr = 1'b1;
         #2;
         checks++;
         if (req_buff_wr !== 2'b10 || sd_buff_din !== v) begin
            errors++;
            $display("FAIL buff_pulse %0d: got wr=%b din=%h expected 10 %h", i, req_buff_wr, sd_buff_din, v);
         end
         sd_buff_wr = 1'b0;
         #2;
         checks++;
         if (req_buff_wr !== 2'b00) begin
            errors++; $display("FAIL buff_low %0d: got %b expected 00", i, req_buff_wr);
         end
      end
      tick(1);
      drop_ack();
      tick(1);
      sd_buff_wr = 1'b1; req_buff_din_1 = 8'h5A; req_buff_din_0 = 8'hA5;
      #1;
      checks++;
      if (req_buff_wr !== 2'b00 || sd_buff_din !== 8'h5A || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_gate: got wr=%b din=%h busy=%b expected 00 5a 0", req_buff_wr, sd_buff_din, busy);
      end
      sd_buff_wr = 1'b0;
   endtask

   task automatic test_rd_over_wr();
      req_rd = 2'b01; req_wr = 2'b01; req_lba_0 = 32'h0000_0777;
      tick(1);
      checks++;
      if ({sd_rd, sd_wr, grant} !== 3'b100 || sd_lba !== 32'h777) begin
         errors++;
         $display("FAIL rd_wins: got rd=%b wr=%b grant=%b lba=%h expected 1 0 0 00000777", sd_rd, sd_wr, grant, sd_lba);
      end
      req_rd = 2'b00; req_wr = 2'b00;
      raise_ack();
      drop_ack();
      tick(1);
   endtask

   task automatic test_round_robin();
      test_reset();
      req_rd = 2'b11; req_lba_0 = 32'h100; req_lba_1 = 32'h200;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         checks++;
         if (grant !== 1'(i % 2) || sd_rd !== 1'b1 || sd_lba !== ((i % 2) ? 32'h200 : 32'h100)) begin
            errors++;
            $display("FAIL rr_grant %0d: got grant=%b rd=%b lba=%h expected %0d 1", i, grant, sd_rd, sd_lba, i % 2);
         end
         raise_ack();
         checks++;
         if (req_ack !== ((i % 2) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_ack %0d: got %b", i, req_ack);
         end
         drop_ack();
         checks++;
         if (busy !== 1'b1 || req_ack !== 2'b00 || sd_rd !== 1'b0) begin
            errors++; $display("FAIL rr_release %0d: got busy=%b ack=%b rd=%b expected 1 00 0", i, busy, req_ack, sd_rd);
         end
         tick(1);
         checks++;
         if (busy !== 1'b0) begin
            errors++; $display("FAIL rr_idle %0d: got busy=%b expected 0", i, busy);
         end
      end
      req_rd = 2'b00;
      tick(1);
   endtask

   task automatic test_timeout();
      req_wr = 2'b01; req_lba_0 = 32'h0000_0042;
      tick(1);
      checks++;
      if ({sd_rd, sd_wr, grant} !== 3'b010) begin
         errors++; $display("FAIL to_grant: got rd=%b wr=%b grant=%b expected 0 1 0", sd_rd, sd_wr, grant);
      end
      req_wr = 2'b00;
      tick(15);
      checks++;
      if (sd_wr !== 1'b1 || req_err !== 2'b00) begin
         errors++; $display("FAIL to_early: got wr=%b err=%b expected 1 00", sd_wr, req_err);
      end
      tick(1);
      checks++;
      if (sd_wr !== 1'b0 || req_err !== 2'b01 || busy !== 1'b1) begin
         errors++; $display("FAIL to_fire: got wr=%b err=%b busy=%b expected 0 01 1", sd_wr, req_err, busy);
      end
      tick(1);
      checks++;
      if (req_err !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL to_after: got err=%b busy=%b expected 00 0", req_err, busy);
      end
   endtask

   task automatic test_reset_mid_xfer();
      req_rd = 2'b11; req_lba_1 = 32'h0000_0999;
      tick(1);
      checks++;
      if (grant !== 1'b1 || sd_rd !== 1'b1) begin
         errors++; $display("FAIL pre_reset_grant: got grant=%b rd=%b expected 1 1", grant, sd_rd);
      end
      raise_ack();
      checks++;
      if (req_ack !== 2'b10) begin
         errors++; $display("FAIL pre_reset_ack: got %b expected 10", req_ack);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({sd_rd, sd_wr, req_ack, busy, grant} !== 6'b0 || sd_lba !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got rd=%b wr=%b ack=%b busy=%b grant=%b lba=%h expected all 0",
                  sd_rd, sd_wr, req_ack, busy, grant, sd_lba);
      end
      sd_ack = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(1);
      checks++;
      if (grant !== 1'b0 || sd_rd !== 1'b1 || sd_lba !== 32'h0000_0123) begin
         errors++; $display("FAIL post_reset_grant: got grant=%b rd=%b lba=%h expected 0 1 00000123", grant, sd_rd, sd_lba);
      end
      req_rd = 2'b00;
   endtask

   initial begin
      test_reset();
      test_read_grant();
      test_xfer_buff();
      test_rd_over_wr();
      test_round_robin();
      test_timeout();
      req_lba_0 = 32'h0000_0123;
      test_reset_mid_xfer();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
